// File: rtl/player_status.sv
// player_status: tracks the player's lives, post-hit invulnerability and the
// death sequence, and reports player_dead back to the game controller.
// Optional feature: define PLAYER_STATUS_EXTRA_LIFE_EN to honour extra_life
// pulses. When it is undefined, extra_life has no effect.
`timescale 1ns/1ps

module player_status #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 5,
  parameter int INVULN_CYCLES = 2_000_000,
  parameter int BLINK_PERIOD  = 250_000,
  parameter int DEATH_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic       hit,
  input  logic       extra_life,
  output logic [2:0] lives,
  output logic       player_dead,
  output logic       invulnerable,
  output logic       blink,
  output logic       dying
);

  // Counter widths hold values 0..N-1 (at least one bit).
  localparam int IW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int DW = (DEATH_CYCLES  > 1) ? $clog2(DEATH_CYCLES)  : 1;
  localparam int BW = (BLINK_PERIOD  > 1) ? $clog2(BLINK_PERIOD)  : 1;

  // Timers are loaded with N-1 and expire on the cycle they read zero, so a
  // timed state lasts exactly N enabled cycles.
  localparam logic [IW-1:0] INVULN_LOAD = IW'(INVULN_CYCLES - 1);
  localparam logic [DW-1:0] DEATH_LOAD  = DW'(DEATH_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_PERIOD - 1);
  localparam logic [2:0]    START_L     = 3'(START_LIVES);
  localparam logic [2:0]    MAX_L       = 3'(MAX_LIVES);

`ifdef PLAYER_STATUS_EXTRA_LIFE_EN
  localparam bit EXTRA_EN = 1'b1;
`else
  localparam bit EXTRA_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_INVULN,
    ST_DYING,
    ST_DEAD
  } state_t;

  state_t        state_q,        state_d;
  logic [2:0]    lives_q,        lives_d;
  logic [IW-1:0] invuln_timer_q, invuln_timer_d;
  logic [DW-1:0] death_timer_q,  death_timer_d;
  logic [BW-1:0] blink_cnt_q,    blink_cnt_d;
  logic          blink_q,        blink_d;
  logic          player_dead_q,  player_dead_d;
  logic          invulnerable_q, invulnerable_d;
  logic          dying_q,        dying_d;

  logic          extra_ok;
  logic          can_grow;

  // Qualify the bonus-life pulse by the build option and saturation ceiling.
  always_comb begin
    extra_ok = EXTRA_EN && extra_life;
    can_grow = extra_ok && (lives_q < MAX_L);
  end

  // Next-state and next-output computation for the whole status machine.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    invuln_timer_d = invuln_timer_q;
    death_timer_d  = death_timer_q;
    blink_cnt_d    = blink_cnt_q;
    blink_d        = blink_q;
    player_dead_d  = player_dead_q;
    invulnerable_d = invulnerable_q;
    dying_d        = dying_q;

    if (clear) begin
      // clear behaves exactly like reset, including mid-INVULN/DYING.
      state_d        = ST_ALIVE;
      lives_d        = START_L;
      invuln_timer_d = '0;
      death_timer_d  = '0;
      blink_cnt_d    = '0;
      blink_d        = 1'b0;
      player_dead_d  = 1'b0;
      invulnerable_d = 1'b0;
      dying_d        = 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            if (extra_ok || (lives_q > 3'd1)) begin
              // A simultaneous bonus cancels the loss, so never fatal then.
              if (!extra_ok) begin
                lives_d = lives_q - 3'd1;
              end
              state_d        = ST_INVULN;
              invuln_timer_d = INVULN_LOAD;
              blink_cnt_d    = '0;
              blink_d        = 1'b0;
              invulnerable_d = 1'b1;
            end else begin
              lives_d        = 3'd0;
              state_d        = ST_DYING;
              death_timer_d  = DEATH_LOAD;
              invulnerable_d = 1'b1;
              dying_d        = 1'b1;
            end
          end else if (can_grow) begin
            lives_d = lives_q + 3'd1;
          end
        end

        ST_INVULN: begin
          if (can_grow) begin
            lives_d = lives_q + 3'd1;
          end
          if (invuln_timer_q == '0) begin
            state_d        = ST_ALIVE;
            blink_cnt_d    = '0;
            blink_d        = 1'b0;
            invulnerable_d = 1'b0;
          end else begin
            invuln_timer_d = invuln_timer_q - IW'(1);
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_d     = ~blink_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end

        ST_DYING: begin
          if (death_timer_q == '0) begin
            state_d        = ST_DEAD;
            player_dead_d  = 1'b1;
            invulnerable_d = 1'b0;
            dying_d        = 1'b0;
          end else begin
            death_timer_d = death_timer_q - DW'(1);
          end
        end

        ST_DEAD: begin
          player_dead_d = 1'b1;
        end

        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_ALIVE;
      lives_q        <= START_L;
      invuln_timer_q <= '0;
      death_timer_q  <= '0;
      blink_cnt_q    <= '0;
      blink_q        <= 1'b0;
      player_dead_q  <= 1'b0;
      invulnerable_q <= 1'b0;
      dying_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      invuln_timer_q <= invuln_timer_d;
      death_timer_q  <= death_timer_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_q        <= blink_d;
      player_dead_q  <= player_dead_d;
      invulnerable_q <= invulnerable_d;
      dying_q        <= dying_d;
    end
  end

  assign lives        = lives_q;
  assign player_dead  = player_dead_q;
  assign invulnerable = invulnerable_q;
  assign blink        = blink_q;
  assign dying        = dying_q;

endmodule

// File: tb/tb_player_status.sv
// Testbench for player_status: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against a behavioural model.
`timescale 1ns/1ps

module tb_player_status;

  localparam int START_LIVES   = 3;
  localparam int MAX_LIVES     = 5;
  localparam int INVULN_CYCLES = 4;
  localparam int BLINK_PERIOD  = 2;
  localparam int DEATH_CYCLES  = 3;

`ifdef PLAYER_STATUS_EXTRA_LIFE_EN
  localparam bit EXTRA_EN = 1'b1;
`else
  localparam bit EXTRA_EN = 1'b0;
`endif

  localparam int M_ALIVE = 0;
  localparam int M_INV   = 1;
  localparam int M_DYING = 2;
  localparam int M_DEAD  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       hit = 1'b0;
  logic       extra_life = 1'b0;
  logic [2:0] lives;
  logic       player_dead;
  logic       invulnerable;
  logic       blink;
  logic       dying;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model state: mode, lives, cycles left in a timed mode, cycles spent in INVULN.
  int m_mode    = M_ALIVE;
  int m_lives   = START_LIVES;
  int m_left    = 0;
  int m_elapsed = 0;
  bit m_valid   = 1'b0;

  player_status #(
    .START_LIVES  (START_LIVES),
    .MAX_LIVES    (MAX_LIVES),
    .INVULN_CYCLES(INVULN_CYCLES),
    .BLINK_PERIOD (BLINK_PERIOD),
    .DEATH_CYCLES (DEATH_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .hit         (hit),
    .extra_life  (extra_life),
    .lives       (lives),
    .player_dead (player_dead),
    .invulnerable(invulnerable),
    .blink       (blink),
    .dying       (dying)
  );

  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Drive one cycle of inputs, then return on the following falling edge.
  task automatic applyStimulus(input bit r, input bit c, input bit en, input bit h, input bit x);
    reset      = r;
    clear      = c;
    enable     = en;
    hit        = h;
    extra_life = x;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Behavioural model: advance by one clock using the game rules directly.
  always @(posedge clk) begin
    cycle++;
    if (reset || clear) begin
      m_mode    = M_ALIVE;
      m_lives   = START_LIVES;
      m_left    = 0;
      m_elapsed = 0;
      m_valid   = 1'b1;
    end else if (enable && m_valid) begin
      if (m_mode == M_ALIVE) begin
        if (hit) begin
          if (EXTRA_EN && extra_life) begin
            m_mode = M_INV; m_left = INVULN_CYCLES; m_elapsed = 0;
          end else if (m_lives > 1) begin
            m_lives = m_lives - 1;
            m_mode = M_INV; m_left = INVULN_CYCLES; m_elapsed = 0;
          end else begin
            m_lives = 0;
            m_mode = M_DYING; m_left = DEATH_CYCLES;
          end
        end else if (EXTRA_EN && extra_life && m_lives < MAX_LIVES) begin
          m_lives = m_lives + 1;
        end
      end else if (m_mode == M_INV) begin
        if (EXTRA_EN && extra_life && m_lives < MAX_LIVES) m_lives = m_lives + 1;
        m_elapsed = m_elapsed + 1;
        m_left    = m_left - 1;
        if (m_left == 0) m_mode = M_ALIVE;
      end else if (m_mode == M_DYING) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_DEAD;
      end
    end
  end

  // Check every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_lives", int'(lives), m_lives);
      checkOutput("model_player_dead", int'(player_dead), int'(m_mode == M_DEAD));
      checkOutput("model_invulnerable", int'(invulnerable), int'(m_mode == M_INV || m_mode == M_DYING));
      checkOutput("model_dying", int'(dying), int'(m_mode == M_DYING));
      checkOutput("model_blink", int'(blink),
                  int'(m_mode == M_INV && ((m_elapsed / BLINK_PERIOD) % 2) == 1));
    end
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=%0d expected=%0d", cycle, 0);
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int exp_x[3];

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_lives", int'(lives), 3);
    checkOutput("reset_dead", int'(player_dead), 0);
    checkOutput("reset_invuln", int'(invulnerable), 0);
    checkOutput("reset_dying", int'(dying), 0);
    checkOutput("reset_blink", int'(blink), 0);
    idle(1);

    // First hit: four invulnerable cycles, second hit ignored, blink 0,0,1,1.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hit1_lives", int'(lives), 2);
    checkOutput("hit1_invuln", int'(invulnerable), 1);
    checkOutput("blink_c0", int'(blink), 0);
    idle(1);
    checkOutput("blink_c1", int'(blink), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("ignored_hit_lives", int'(lives), 2);
    checkOutput("blink_c2", int'(blink), 1);
    idle(1);
    checkOutput("blink_c3", int'(blink), 1);
    checkOutput("invuln_c3", int'(invulnerable), 1);
    idle(1);
    checkOutput("invuln_end", int'(invulnerable), 0);
    checkOutput("blink_end", int'(blink), 0);

    // Down to zero lives, death sequence, then clear.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hit2_lives", int'(lives), 1);
    idle(4);
    checkOutput("hit2_recovered", int'(invulnerable), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hit3_lives", int'(lives), 0);
    checkOutput("dying_d0", int'(dying), 1);
    checkOutput("dying_invuln", int'(invulnerable), 1);
    idle(2);
    checkOutput("dying_d2", int'(dying), 1);
    checkOutput("dead_not_yet", int'(player_dead), 0);
    idle(1);
    checkOutput("dead_rise", int'(player_dead), 1);
    checkOutput("dead_dying_low", int'(dying), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    checkOutput("dead_held", int'(player_dead), 1);
    checkOutput("dead_lives", int'(lives), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_lives", int'(lives), 3);
    checkOutput("clear_dead", int'(player_dead), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("clear_beats_hit", int'(lives), 3);

    // Freeze in the middle of invulnerability.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("freeze_invuln", int'(invulnerable), 1);
    checkOutput("freeze_lives", int'(lives), 2);
    idle(3);
    checkOutput("thaw_invuln_c3", int'(invulnerable), 1);
    idle(1);
    checkOutput("thaw_invuln_end", int'(invulnerable), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("frozen_hit_dropped", int'(lives), 2);
    idle(1);

    // Bonus lives and saturation.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    if (EXTRA_EN) begin
      exp_x[0] = 4; exp_x[1] = 5; exp_x[2] = 5;
    end else begin
      exp_x[0] = 3; exp_x[1] = 3; exp_x[2] = 3;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("extra_lives", int'(lives), exp_x[i]);
    end

    // Simultaneous hit and bonus on the last life.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    checkOutput("last_life", int'(lives), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("hit_extra_lives", int'(lives), EXTRA_EN ? 1 : 0);
    checkOutput("hit_extra_dying", int'(dying), EXTRA_EN ? 0 : 1);
    checkOutput("hit_extra_invuln", int'(invulnerable), 1);
    idle(6);

    // Clear during the death sequence.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("mid_dying_d0", int'(dying), 1);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_clear_lives", int'(lives), 3);
    checkOutput("mid_clear_dying", int'(dying), 0);
    checkOutput("mid_clear_dead", int'(player_dead), 0);
    idle(5);
    checkOutput("mid_clear_never_dead", int'(player_dead), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
